// File: rtl/vpu_req_arbiter.sv
// Round-robin arbiter feeding one VPU decoder, with in-flight credit limiting.
// Optional macro VPU_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module vpu_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int INSTR_W      = 64,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       dec_valid_o,
  output logic [INSTR_W-1:0]         dec_instr_o,
  output logic [$clog2(NUM_REQ)-1:0] dec_src_o,
  input  logic                       dec_ready_i,
  input  logic                       cpl_valid_i,
  output logic [CNT_W-1:0]           inflight_o,
  output logic                       busy_o,
  output logic                       err_o
);
  // Handshakes: a transfer happens on any cycle where valid and ready are both high at the rising
  // edge; the sender holds valid and payload stable until then. req_ready_o is the grant pulse.
  localparam int SRC_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t            state;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  winner;
  logic [SRC_W-1:0]  rr_next;
  logic              found;
  logic              any_valid;
  logic              credit_idle;
  logic              credit_issue;
  logic              grant_en;
  logic              rr_upd;
  logic              issue;
  logic [CNT_W:0]    inflight_plus1;
  logic [CNT_W-1:0]  inflight;
  int                idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
`ifdef VPU_ARB_PRIO0_EN
    if (req_valid_i[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
  end

  assign any_valid      = |req_valid_i;
  assign issue          = dec_valid_o && dec_ready_i;
  assign inflight_plus1 = {1'b0, inflight} + (CNT_W + 1)'(1);
  // Grants only look at the registered count; a same-cycle completion frees its credit next cycle.
  assign credit_idle    = inflight < CNT_W'(MAX_INFLIGHT);
  assign credit_issue   = inflight_plus1 < (CNT_W + 1)'(MAX_INFLIGHT);
  assign grant_en       = !rst && any_valid &&
                          ((state == IDLE && credit_idle) ||
                           (state == ISSUE && dec_ready_i && credit_issue));
  assign rr_next        = (int'(winner) == NUM_REQ - 1) ? '0 : winner + SRC_W'(1);

`ifdef VPU_ARB_PRIO0_EN
  assign rr_upd = grant_en && (winner != '0);
`else
  assign rr_upd = grant_en;
`endif

  always_comb begin
    req_ready_o = '0;
    if (grant_en) req_ready_o[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      dec_instr_o <= '0;
      dec_src_o   <= '0;
    end else begin
      if (grant_en) begin
        state       <= ISSUE;
        dec_instr_o <= req_instr_i[int'(winner)*INSTR_W +: INSTR_W];
        dec_src_o   <= winner;
        if (rr_upd) rr_ptr <= rr_next;
      end else if (state == ISSUE && dec_ready_i) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      err_o    <= 1'b0;
    end else begin
      if (issue && !cpl_valid_i) begin
        inflight <= inflight + CNT_W'(1);
      end else if (!issue && cpl_valid_i) begin
        if (inflight != '0) inflight <= inflight - CNT_W'(1);
        else                err_o    <= 1'b1;
      end
    end
  end

  // The state register itself drives dec_valid_o, so the FSM state is always observable.
  assign dec_valid_o = (state == ISSUE);
  assign inflight_o  = inflight;
  assign busy_o      = dec_valid_o || (inflight != '0);

endmodule
